hazard_scoreboard: RTL

- Parametrised successor of the per-stage control decode. Tracks destination register, valid bit and Tnew for the E, M and W pipeline slots.
- Sits beside the D stage:
  - compares D-stage source registers and their Tuse against the in-flight slots;
  - drives the D-stage stall and the D-stage forwarding selects.
- Adds a multi-cycle mult/div busy counter with configurable latencies, which the per-stage decoders lack.

---
 rtl/hazard_scoreboard_if.sv | 32 +++
 rtl/hazard_scoreboard.sv | 82 ++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: D-stage hazard query bus between decode (master) and the scoreboard (slave).
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int TNEW_W = 2
);
  logic [REG_AW-1:0] d_rs_addr;
  logic              d_rs_use_vld;
  logic [TNEW_W-1:0] d_rs_tuse;
  logic [REG_AW-1:0] d_rt_addr;
  logic              d_rt_use_vld;
  logic [TNEW_W-1:0] d_rt_tuse;
  logic [REG_AW-1:0] d_dst_addr;
  logic              d_dst_vld;
  logic [TNEW_W-1:0] d_tnew;
  logic              d_md_use;
  logic [1:0]        d_md_start;
  logic              stall_d;
  logic [1:0]        fwd_rs_sel;
  logic [1:0]        fwd_rt_sel;
  logic              md_busy;
  logic [15:0]       perf_stall_cnt;
  modport master (
    output d_rs_addr, d_rs_use_vld, d_rs_tuse, d_rt_addr, d_rt_use_vld, d_rt_tuse,
           d_dst_addr, d_dst_vld, d_tnew, d_md_use, d_md_start,
    input  stall_d, fwd_rs_sel, fwd_rt_sel, md_busy, perf_stall_cnt
  );
  modport slave (
    input  d_rs_addr, d_rs_use_vld, d_rs_tuse, d_rt_addr, d_rt_use_vld, d_rt_tuse,
           d_dst_addr, d_dst_vld, d_tnew, d_md_use, d_md_start,
    output stall_d, fwd_rs_sel, fwd_rt_sel, md_busy, perf_stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: E/M/W slot tracking, D-stage stall/forward selects and mult/div busy counter.
// Define HAZARD_PERF_EN to build the saturating stall-cycle counter on perf_stall_cnt.
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int TNEW_W   = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input logic clk,
  input logic reset_n,
  hazard_scoreboard_if.slave bus
);
  logic [REG_AW-1:0] e_addr, m_addr, w_addr;
  logic              e_vld, m_vld, w_vld;
  logic [TNEW_W-1:0] e_tnew, m_tnew, w_tnew;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [REG_AW-1:0] src_addr [2];
  logic              src_use  [2];
  logic [TNEW_W-1:0] src_tuse [2];
  logic [1:0]        src_sel  [2];
  logic [1:0]        dstall;
  logic              stall, md_stall;
  function automatic logic [TNEW_W-1:0] dec(input logic [TNEW_W-1:0] t);
    return (t != '0) ? t - TNEW_W'(1) : t;
  endfunction
  assign src_addr[0] = bus.d_rs_addr;
  assign src_use[0]  = bus.d_rs_use_vld;
  assign src_tuse[0] = bus.d_rs_tuse;
  assign src_addr[1] = bus.d_rt_addr;
  assign src_use[1]  = bus.d_rt_use_vld;
  assign src_tuse[1] = bus.d_rt_tuse;
  for (genvar s = 0; s < 2; s++) begin : g_src
    logic              hit_e, hit_m, hit_w, hit;
    logic [TNEW_W-1:0] t;
    assign hit_e = src_use[s] && src_addr[s] != '0 && e_vld && e_addr == src_addr[s];
    assign hit_m = src_use[s] && src_addr[s] != '0 && m_vld && m_addr == src_addr[s];
    assign hit_w = src_use[s] && src_addr[s] != '0 && w_vld && w_addr == src_addr[s];
    assign hit   = hit_e | hit_m | hit_w;
    // only the youngest matching slot decides both stall and forwarding
    assign t          = hit_e ? e_tnew : hit_m ? m_tnew : w_tnew;
    assign dstall[s]  = hit && t > src_tuse[s];
    assign src_sel[s] = (!hit || t != '0) ? 2'b00 : hit_e ? 2'b01 : hit_m ? 2'b10 : 2'b11;
  end
  assign md_stall       = bus.d_md_use && cnt != '0;
  assign stall          = dstall[0] | dstall[1] | md_stall;
  assign bus.stall_d    = stall;
  assign bus.fwd_rs_sel = src_sel[0];
  assign bus.fwd_rt_sel = src_sel[1];
  assign bus.md_busy    = cnt != '0;
  // a fresh start overrides any remaining count; a stalled start is ignored
  always_comb begin
    cnt_nxt = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    cnt_nxt = (!stall && bus.d_md_start == 2'b01) ? CNT_W'(MULT_CYC) :
              (!stall && bus.d_md_start == 2'b10) ? CNT_W'(DIV_CYC) : cnt_nxt;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {e_addr, e_vld, e_tnew} <= '0;
      {m_addr, m_vld, m_tnew} <= '0;
      {w_addr, w_vld, w_tnew} <= '0;
      cnt <= '0;
    end else begin
      {w_addr, w_vld, w_tnew} <= {m_addr, m_vld, dec(m_tnew)};
      {m_addr, m_vld, m_tnew} <= {e_addr, e_vld, dec(e_tnew)};
      e_addr <= bus.d_dst_addr;
      e_vld  <= !stall && bus.d_dst_vld && bus.d_dst_addr != '0;
      e_tnew <= bus.d_tnew;
      cnt    <= cnt_nxt;
    end
  end
`ifdef HAZARD_PERF_EN
  logic [15:0] perf;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perf <= '0;
    else if (stall && perf != 16'hFFFF) perf <= perf + 16'd1;
  end
  assign bus.perf_stall_cnt = perf;
`else
  assign bus.perf_stall_cnt = '0;
`endif
endmodule
